// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory arbiter.
package mem_arb_pkg;

    // Requester that owns the read currently returning from the memory unit.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    // Memory-mapped I/O locations decoded inside the memory unit.
    localparam logic [9:0] IO_PORT0 = 10'h3F4;
    localparam logic [9:0] IO_PORT1 = 10'h3F8;
    localparam logic [9:0] IO_OUT   = 10'h3FC;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/DM requesters, the arbiter and the memory unit.
// slave  : arbiter side (consumes requests and mem_rdata)
// master : environment side (requesters plus memory unit)
interface mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_ready, if_valid, if_rdata,
        output dm_ready, dm_valid, dm_rdata,
        output mem_addr, mem_wdata, mem_we, mem_rd
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_ready, if_valid, if_rdata,
        input  dm_ready, dm_valid, dm_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_rd
    );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port arbiter sharing the memory unit between instruction fetch and
// data memory. DM normally wins; IF is forced through after STARVE_MAX
// consecutive denied cycles. Reads return one cycle later to their issuer.
//
// owner (read-return tracker)
//   state    | meaning
//   OWN_NONE | no read data returning this cycle
//   OWN_IF   | mem_rdata this cycle belongs to IF
//   OWN_DM   | mem_rdata this cycle belongs to DM
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    owner_t            r_owner;
    owner_t            w_owner_nxt;
    logic [3:0]        r_starve_cnt;
    logic [3:0]        w_starve_nxt;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_wdata_hold;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic              w_starved;
    logic              w_if_win;
    logic              w_dm_win;
    logic              w_if_valid;
    logic              w_dm_valid;

    // Grant decision; nothing is granted while reset is asserted so the
    // memory unit sees a quiet bus during reset.
    always_comb begin
        w_starved = (r_starve_cnt == C_STARVE_MAX);
        w_if_win  = rst & bus.if_req & (~bus.dm_req | w_starved);
        w_dm_win  = rst & bus.dm_req & ~w_if_win;
    end

    // State register: read owner and IF starvation counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner      <= OWN_NONE;
            r_starve_cnt <= 4'd0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Next-state: a read grant claims the next cycle's return data; the
    // counter tracks consecutive denied IF cycles and saturates.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_if_win) begin
            w_owner_nxt = OWN_IF;
        end else if (w_dm_win && !bus.dm_we) begin
            w_owner_nxt = OWN_DM;
        end

        w_starve_nxt = r_starve_cnt;
        if (!bus.if_req || w_if_win) begin
            w_starve_nxt = 4'd0;
        end else if (r_starve_cnt < C_STARVE_MAX) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
        end
    end

    // Holding registers: last driven address/data, last returned data per port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
        end else begin
            if (w_if_win) begin
                r_addr_hold  <= bus.if_addr;
                r_wdata_hold <= '0;
            end else if (w_dm_win) begin
                r_addr_hold  <= bus.dm_addr;
                r_wdata_hold <= bus.dm_wdata;
            end
            if (r_owner == OWN_IF) begin
                r_if_rdata <= bus.mem_rdata;
            end
            if (r_owner == OWN_DM) begin
                r_dm_rdata <= bus.mem_rdata;
            end
        end
    end

    // Outputs: memory-unit drive from the winner, return-data steering.
    always_comb begin
        w_if_valid    = (r_owner == OWN_IF);
        w_dm_valid    = (r_owner == OWN_DM);

        bus.if_ready  = w_if_win;
        bus.dm_ready  = w_dm_win;
        bus.mem_addr  = r_addr_hold;
        bus.mem_wdata = r_wdata_hold;
        bus.mem_we    = 1'b0;
        bus.mem_rd    = 1'b0;
        if (w_if_win) begin
            bus.mem_addr  = bus.if_addr;
            bus.mem_wdata = '0;
            bus.mem_rd    = 1'b1;
        end else if (w_dm_win) begin
            bus.mem_addr  = bus.dm_addr;
            bus.mem_wdata = bus.dm_wdata;
            bus.mem_we    = bus.dm_we;
            bus.mem_rd    = ~bus.dm_we;
        end

        bus.if_valid  = w_if_valid;
        bus.dm_valid  = w_dm_valid;
        bus.if_rdata  = w_if_valid ? bus.mem_rdata : r_if_rdata;
        bus.dm_rdata  = w_dm_valid ? bus.mem_rdata : r_dm_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all
// checked each cycle against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SM = 3;

    logic clk;
    logic rst;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory unit: RAM with registered read, output port latched at IO_OUT.
    logic [DW-1:0] ram [0:1023];
    logic [DW-1:0] out_port;
    always @(posedge clk) begin
        if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_addr == IO_OUT) out_port <= bus.mem_wdata;
        end
        if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:1023];
    int            m_wait;        // consecutive cycles IF has been refused
    int            m_pend_who;    // 0 none, 1 IF, 2 DM
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] m_if_hold, m_dm_hold;
    logic [AW-1:0] m_addr_hold;
    logic [DW-1:0] m_wdata_hold;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_word(input logic [AW-1:0] a, input logic [DW-1:0] v);
        ram[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic model_reset();
        m_wait       = 0;
        m_pend_who   = 0;
        m_pend_data  = '0;
        m_if_hold    = '0;
        m_dm_hold    = '0;
        m_addr_hold  = '0;
        m_wdata_hold = '0;
    endtask

    // One clock cycle with the currently driven inputs: compare every output
    // with the model, advance the model, return the observed grants.
    task automatic run_cycle(output bit g_if, output bit g_dm);
        bit            e_if, e_dm, e_ifv, e_dmv, e_we, e_rd;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        #1;
        e_if  = bus.if_req && (!bus.dm_req || m_wait >= SM);
        e_dm  = bus.dm_req && !e_if;
        e_ifv = (m_pend_who == 1);
        e_dmv = (m_pend_who == 2);
        e_addr = m_addr_hold; e_wdata = m_wdata_hold; e_we = 0; e_rd = 0;
        if (e_if) begin
            e_addr = bus.if_addr; e_wdata = '0; e_rd = 1;
        end else if (e_dm) begin
            e_addr = bus.dm_addr; e_wdata = bus.dm_wdata; e_we = bus.dm_we; e_rd = !bus.dm_we;
        end

        chk("if_ready",  32'(bus.if_ready), 32'(e_if));
        chk("dm_ready",  32'(bus.dm_ready), 32'(e_dm));
        chk("if_valid",  32'(bus.if_valid), 32'(e_ifv));
        chk("dm_valid",  32'(bus.dm_valid), 32'(e_dmv));
        chk("if_rdata",  bus.if_rdata, e_ifv ? m_pend_data : m_if_hold);
        chk("dm_rdata",  bus.dm_rdata, e_dmv ? m_pend_data : m_dm_hold);
        chk("mem_we",    32'(bus.mem_we), 32'(e_we));
        chk("mem_rd",    32'(bus.mem_rd), 32'(e_rd));
        chk("mem_addr",  32'(bus.mem_addr), 32'(e_addr));
        chk("mem_wdata", bus.mem_wdata, e_wdata);

        if (e_ifv) m_if_hold = m_pend_data;
        if (e_dmv) m_dm_hold = m_pend_data;
        m_pend_who = 0;
        if (e_if) begin
            m_pend_who = 1; m_pend_data = ref_mem[bus.if_addr];
        end else if (e_dm && !bus.dm_we) begin
            m_pend_who = 2; m_pend_data = ref_mem[bus.dm_addr];
        end else if (e_dm) begin
            ref_mem[bus.dm_addr] = bus.dm_wdata;
        end
        if (e_if || e_dm) begin
            m_addr_hold = e_addr; m_wdata_hold = e_wdata;
        end
        if (!bus.if_req || e_if) m_wait = 0;
        else if (m_wait < SM)    m_wait = m_wait + 1;

        g_if = bus.if_ready;
        g_dm = bus.dm_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'({bus.if_ready, bus.dm_ready}), 32'd0);
        chk({tag, "_valid"}, 32'({bus.if_valid, bus.dm_valid}), 32'd0);
        chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
        chk({tag, "_dm_rdata"}, bus.dm_rdata, 32'd0);
        chk({tag, "_mem_ctl"}, 32'({bus.mem_we, bus.mem_rd}), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gi, gd, pgi, pgd;
        logic [4:0] ifpat, dmpat;
        int dm_cnt;

        for (int i = 0; i < 1024; i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            ram[i] = v; ref_mem[i] = v;
        end
        set_word(10'h010, 32'hDEADBEEF);
        set_word(IO_PORT0, 32'h0000_0011);
        set_word(IO_PORT1, 32'h0000_0033);
        set_word(10'h004, 32'h0000_0022);
        bus.mem_rdata = '0;
        out_port = '0;

        // Reset with both requesters active: bus must stay quiet.
        rst = 1'b0;
        bus.if_req = 1; bus.if_addr = 10'h010;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 10'h020; bus.dm_wdata = 32'h1234_5678;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_all_zero("reset");
        end
        rst = 1'b1;
        run_cycle(gi, gd);
        chk("first_grant_dm", 32'({gi, gd}), 32'b01);
        chk("first_read_dm_valid", 32'(bus.dm_valid), 32'd1);
        chk("first_read_dm_rdata", bus.dm_rdata, ref_mem[10'h020]);

        // Lone IF read of 0x010.
        bus.dm_req = 0; bus.if_req = 0;
        run_cycle(gi, gd);
        bus.if_req = 1; bus.if_addr = 10'h010;
        run_cycle(gi, gd);
        chk("lone_if_ready", 32'(gi), 32'd1);
        bus.if_req = 0;
        chk("lone_if_valid", 32'(bus.if_valid), 32'd1);
        chk("lone_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        chk("lone_dm_valid", 32'(bus.dm_valid), 32'd0);
        run_cycle(gi, gd);

        // Contention: DM alternating write/read, IF held high throughout.
        bus.if_req = 1; bus.if_addr = 10'h040;
        dm_cnt = 0; gd = 1; ifpat = '0; dmpat = '0;
        for (int k = 0; k < 5; k++) begin
            if (gd) begin
                bus.dm_req = 1; bus.dm_we = (dm_cnt % 2 == 0);
                bus.dm_addr = 10'(10'h100 + dm_cnt); bus.dm_wdata = $urandom;
                dm_cnt++;
            end
            run_cycle(gi, gd);
            ifpat[k] = gi; dmpat[k] = gd;
        end
        chk("contention_if_pattern", 32'(ifpat), 32'b01000);
        chk("contention_dm_pattern", 32'(dmpat), 32'b10111);
        bus.if_req = 0; bus.dm_req = 0;
        run_cycle(gi, gd);

        // Write to the output port.
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = IO_OUT; bus.dm_wdata = 32'h0000_00A5;
        run_cycle(gi, gd);
        chk("outwr_grant", 32'(gd), 32'd1);
        bus.dm_req = 0;
        chk("outwr_no_valid", 32'(bus.dm_valid), 32'd0);
        chk("outwr_port", out_port, 32'h0000_00A5);
        run_cycle(gi, gd);

        // Back-to-back reads: DM at T, IF at T+1.
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = IO_PORT0;
        run_cycle(gi, gd);
        bus.dm_req = 0; bus.if_req = 1; bus.if_addr = 10'h004;
        chk("b2b_dm_valid", 32'(bus.dm_valid), 32'd1);
        chk("b2b_dm_rdata", bus.dm_rdata, 32'h0000_0011);
        run_cycle(gi, gd);
        bus.if_req = 0;
        chk("b2b_if_valid", 32'(bus.if_valid), 32'd1);
        chk("b2b_if_rdata", bus.if_rdata, 32'h0000_0022);
        chk("b2b_dm_gone", 32'(bus.dm_valid), 32'd0);
        run_cycle(gi, gd);

        // Randomized traffic obeying hold-until-ready.
        pgi = 1; pgd = 1;
        for (int k = 0; k < 600; k++) begin
            if (!bus.if_req || pgi) begin
                bus.if_req  = ($urandom_range(0, 3) != 0);
                bus.if_addr = 10'($urandom_range(0, 1023));
            end
            if (!bus.dm_req || pgd) begin
                bus.dm_req   = ($urandom_range(0, 3) != 0);
                bus.dm_we    = $urandom_range(0, 1) == 1;
                bus.dm_addr  = 10'($urandom_range(0, 1023));
                bus.dm_wdata = $urandom;
            end
            run_cycle(pgi, pgd);
        end

        // Reset in the cycle a DM read is returning: data is dropped.
        bus.if_req = 0;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 10'h004;
        run_cycle(gi, gd);
        bus.dm_req = 0;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        run_cycle(gi, gd);
        run_cycle(gi, gd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
